// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : MEM-stage data-memory access controller (RV32IM).
// Optional macro MEM_ACCESS_TIMEOUT_EN adds an ACCESS-state timeout abort.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ_EN,
    input  logic        MEM_WRITE_EN,
    input  logic [2:0]  MEM_FUNCT3,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_WRITE_DATA,
    output logic [31:0] DATA_MEM_READ_DATA,
    output logic        STALL,
    output logic        ACCESS_FAULT,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BE,
    output logic        DMEM_READ,
    output logic        DMEM_WRITE,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_READY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic        r_read, r_write, r_to_fault;
    logic [2:0]  r_f3;
    logic [1:0]  r_alo;

    logic        w_rd_only, w_wr_only, w_legal, w_misalign, w_valid, w_fault;
    logic        w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_fmt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_rd_only  = MEM_READ_EN & ~MEM_WRITE_EN;
    assign w_wr_only  = MEM_WRITE_EN & ~MEM_READ_EN;
    // Loads accept 000/001/010/100/101; stores accept 000/001/010.
    assign w_legal    = (MEM_FUNCT3[1:0] != 2'b11) &&
                        (w_rd_only ? (MEM_FUNCT3 != 3'b110) : ~MEM_FUNCT3[2]);
    assign w_misalign = ((MEM_FUNCT3[1:0] == 2'b01) && MEM_ADDR[0]) ||
                        ((MEM_FUNCT3[1:0] == 2'b10) && (MEM_ADDR[1:0] != 2'b00));
    assign w_valid    = (w_rd_only | w_wr_only) & w_legal & ~w_misalign;
    assign w_fault    = (MEM_READ_EN | MEM_WRITE_EN) & ~w_valid;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = MEM_WRITE_DATA;
        case (MEM_FUNCT3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << MEM_ADDR[1:0];
                w_wdata = {4{MEM_WRITE_DATA[7:0]}};
            end
            2'b01: begin
                w_be    = MEM_ADDR[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{MEM_WRITE_DATA[15:0]}};
            end
            default: ;
        endcase
    end

    // Formatting uses the funct3/lane latched at request time.
    always_comb begin
        w_byte = DMEM_RDATA[7:0];
        case (r_alo)
            2'd1:    w_byte = DMEM_RDATA[15:8];
            2'd2:    w_byte = DMEM_RDATA[23:16];
            2'd3:    w_byte = DMEM_RDATA[31:24];
            default: ;
        endcase
        w_half = r_alo[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
        case (r_f3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = DMEM_RDATA;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [4:0] c_TO_LAST = 5'(TIMEOUT_CYCLES - 1);
    logic [4:0] r_cnt;

    assign w_expire = (r_cnt == c_TO_LAST);

    always_ff @(posedge CLK) begin
        if (RESET || r_state != S_ACCESS) begin
            r_cnt <= 5'd0;
        end else begin
            r_cnt <= r_cnt + 5'd1;
        end
    end
`else
    // No counter: ACCESS waits for DMEM_READY indefinitely.
    assign w_expire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        STALL  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    STALL  = 1'b1;
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                STALL = 1'b1;
                if (DMEM_READY || w_expire) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_be       <= 4'd0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_to_fault <= 1'b0;
            r_f3       <= 3'd0;
            r_alo      <= 2'd0;
        end else begin
            r_to_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_addr  <= {MEM_ADDR[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_read  <= w_rd_only;
                        r_write <= w_wr_only;
                        r_f3    <= MEM_FUNCT3;
                        r_alo   <= MEM_ADDR[1:0];
                    end else if (w_fault) begin
                        r_rdata <= 32'd0;
                    end
                end
                S_ACCESS: begin
                    if (DMEM_READY) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_read) begin
                            r_rdata <= w_load_fmt;
                        end
                    end else if (w_expire) begin
                        r_read     <= 1'b0;
                        r_write    <= 1'b0;
                        r_rdata    <= 32'd0;
                        r_to_fault <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ACCESS_FAULT       = ((r_state == S_IDLE) & w_fault) | r_to_fault;
    assign DATA_MEM_READ_DATA = ((r_state == S_IDLE) & w_fault) ? 32'd0 : r_rdata;
    assign DMEM_ADDR          = r_addr;
    assign DMEM_WDATA         = r_wdata;
    assign DMEM_BE            = r_be;
    assign DMEM_READ          = r_read;
    assign DMEM_WRITE         = r_write;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit : self-checking bench with a behavioural memory model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        MEM_READ_EN = 1'b0, MEM_WRITE_EN = 1'b0;
    logic [2:0]  MEM_FUNCT3 = 3'd0;
    logic [31:0] MEM_ADDR = 32'd0, MEM_WRITE_DATA = 32'd0;
    logic [31:0] DATA_MEM_READ_DATA, DMEM_ADDR, DMEM_WDATA;
    logic [31:0] DMEM_RDATA = 32'd0;
    logic        STALL, ACCESS_FAULT, DMEM_READ, DMEM_WRITE;
    logic        DMEM_READY = 1'b0;
    logic [3:0]  DMEM_BE;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_rdata = 32'd0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .MEM_READ_EN(MEM_READ_EN), .MEM_WRITE_EN(MEM_WRITE_EN),
        .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .DATA_MEM_READ_DATA(DATA_MEM_READ_DATA),
        .STALL(STALL), .ACCESS_FAULT(ACCESS_FAULT),
        .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE),
        .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE),
        .DMEM_RDATA(DMEM_RDATA), .DMEM_READY(DMEM_READY)
    );

    initial forever #5 CLK = ~CLK;

    // Access size in bytes from funct3 (0 = illegal width code).
    function automatic int m_size(input logic [2:0] f3);
        int s;
        s = 1 << f3[1:0];
        if (s == 8) s = 0;
        return s;
    endfunction

    function automatic bit m_valid(input logic re, we, input logic [2:0] f3,
                                   input logic [31:0] a);
        int s;
        s = m_size(f3);
        if ((re + we) != 1) return 0;
        if (s == 0) return 0;
        if (we && f3[2]) return 0;
        if (re && s == 4 && f3[2]) return 0;
        return (a % s) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        int s;
        longint unsigned v, mask;
        s = m_size(f3);
        if (s == 4) return word;
        mask = (64'd1 << (8 * s)) - 1;
        v = (64'(word) >> (8 * (a % 4))) & mask;
        if (!f3[2] && v[8*s-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++;
        if ({STALL, ACCESS_FAULT, DMEM_READ, DMEM_WRITE} !== 4'b0 || DMEM_BE !== 4'b0 ||
            DMEM_ADDR !== 32'd0 || DMEM_WDATA !== 32'd0 || DATA_MEM_READ_DATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: stall=%b fault=%b rd=%b wr=%b be=%b addr=%h wd=%h rdata=%h, all must be 0",
                     STALL, ACCESS_FAULT, DMEM_READ, DMEM_WRITE, DMEM_BE, DMEM_ADDR, DMEM_WDATA, DATA_MEM_READ_DATA);
        end
    endtask

    // One instruction in the MEM stage; memory answers after dly extra ACCESS cycles.
    task automatic run_txn(input logic re, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] word, input int dly);
        int s, stalls;
        logic [31:0] exp_wd;
        logic [3:0] exp_be;
        s = m_size(f3);
        @(negedge CLK);
        MEM_READ_EN = re; MEM_WRITE_EN = we; MEM_FUNCT3 = f3;
        MEM_ADDR = a; MEM_WRITE_DATA = wd;
        DMEM_READY = 1'b0;
        #1;
        if (!re && !we) begin
            checks++;
            if (STALL !== 1'b0 || ACCESS_FAULT !== 1'b0 || DATA_MEM_READ_DATA !== m_rdata) begin
                errors++;
                $display("FAIL no_request: stall=%b fault=%b rdata=%h, want 0 0 %h",
                         STALL, ACCESS_FAULT, DATA_MEM_READ_DATA, m_rdata);
            end
            return;
        end
        if (!m_valid(re, we, f3, a)) begin
            m_rdata = 32'd0;
            checks++;
            if (STALL !== 1'b0 || ACCESS_FAULT !== 1'b1 || DATA_MEM_READ_DATA !== 32'd0 ||
                DMEM_READ !== 1'b0 || DMEM_WRITE !== 1'b0) begin
                errors++;
                $display("FAIL fault_resp f3=%b a=%h: stall=%b fault=%b rdata=%h rd=%b wr=%b, want 0 1 0 0 0",
                         f3, a, STALL, ACCESS_FAULT, DATA_MEM_READ_DATA, DMEM_READ, DMEM_WRITE);
            end
            @(negedge CLK);
            MEM_READ_EN = 1'b0; MEM_WRITE_EN = 1'b0;
            #1;
            checks++;
            if (ACCESS_FAULT !== 1'b0 || STALL !== 1'b0 || DMEM_READ !== 1'b0 ||
                DMEM_WRITE !== 1'b0 || DATA_MEM_READ_DATA !== 32'd0) begin
                errors++;
                $display("FAIL fault_after: fault=%b stall=%b rd=%b wr=%b rdata=%h, want 0 0 0 0 0",
                         ACCESS_FAULT, STALL, DMEM_READ, DMEM_WRITE, DATA_MEM_READ_DATA);
            end
            return;
        end
        stalls = (STALL === 1'b1) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            exp_be[i] = (i >= (a % 4)) && (i < (a % 4) + s);
            exp_wd[8*i +: 8] = wd[8*(i % s) +: 8];
        end
        for (int k = 0; k <= dly; k++) begin
            @(negedge CLK);
            DMEM_READY = (k == dly);
            DMEM_RDATA = (k == dly) ? word : $urandom;
            #1;
            if (STALL === 1'b1) stalls++;
            checks++;
            if (DMEM_ADDR !== (a & 32'hFFFF_FFFC) || DMEM_READ !== re || DMEM_WRITE !== we ||
                (we && (DMEM_BE !== exp_be || DMEM_WDATA !== exp_wd))) begin
                errors++;
                $display("FAIL bus_access cyc%0d: addr=%h rd=%b wr=%b be=%b wd=%h, want %h %b %b %b %h",
                         k, DMEM_ADDR, DMEM_READ, DMEM_WRITE, DMEM_BE, DMEM_WDATA,
                         a & 32'hFFFF_FFFC, re, we, exp_be, exp_wd);
            end
        end
        if (re) m_rdata = m_load(f3, a, word);
        @(negedge CLK);
        DMEM_READY = 1'b0;
        DMEM_RDATA = $urandom;
        #1;
        checks++;
        if (STALL !== 1'b0 || DMEM_READ !== 1'b0 || DMEM_WRITE !== 1'b0 ||
            ACCESS_FAULT !== 1'b0 || DATA_MEM_READ_DATA !== m_rdata) begin
            errors++;
            $display("FAIL done_state f3=%b a=%h: stall=%b rd=%b wr=%b fault=%b rdata=%h, want 0 0 0 0 %h",
                     f3, a, STALL, DMEM_READ, DMEM_WRITE, ACCESS_FAULT, DATA_MEM_READ_DATA, m_rdata);
        end
        checks++;
        if (stalls != dly + 2) begin
            errors++;
            $display("FAIL stall_cycles: got %0d, want %0d", stalls, dly + 2);
        end
        @(negedge CLK);
        MEM_READ_EN = 1'b0; MEM_WRITE_EN = 1'b0;
        #1;
        checks++;
        if (STALL !== 1'b0 || DMEM_READ !== 1'b0 || DATA_MEM_READ_DATA !== m_rdata) begin
            errors++;
            $display("FAIL back_to_idle: stall=%b rd=%b rdata=%h, want 0 0 %h",
                     STALL, DMEM_READ, DATA_MEM_READ_DATA, m_rdata);
        end
    endtask

    task automatic test_directed();
        run_txn(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        checks++;
        if (m_rdata !== 32'hDEADBEEF || DATA_MEM_READ_DATA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_value: got %h, want deadbeef", DATA_MEM_READ_DATA);
        end
        run_txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);
        checks++;
        if (DATA_MEM_READ_DATA !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_value: got %h, want ffffff80", DATA_MEM_READ_DATA);
        end
        run_txn(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2);
        checks++;
        if (DATA_MEM_READ_DATA !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_value: got %h, want 00000080", DATA_MEM_READ_DATA);
        end
        run_txn(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 2);
        run_txn(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        run_txn(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
        run_txn(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    endtask

    task automatic test_ready_outside_access();
        run_txn(1, 0, 3'b101, 32'h402, 32'h0, 32'h9876_5432, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            DMEM_READY = 1'b1;
            DMEM_RDATA = $urandom;
            #1;
            checks++;
            if (STALL !== 1'b0 || DMEM_READ !== 1'b0 || DATA_MEM_READ_DATA !== m_rdata) begin
                errors++;
                $display("FAIL stray_ready: stall=%b rd=%b rdata=%h, want 0 0 %h",
                         STALL, DMEM_READ, DATA_MEM_READ_DATA, m_rdata);
            end
        end
        DMEM_READY = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        @(negedge CLK);
        MEM_READ_EN = 1'b1; MEM_FUNCT3 = 3'b010; MEM_ADDR = 32'h300;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1; DMEM_READY = 1'b1; DMEM_RDATA = 32'h12345678;
        @(negedge CLK);
        RESET = 1'b0; DMEM_READY = 1'b0; MEM_READ_EN = 1'b0;
        m_rdata = 32'd0;
        #1;
        checks++;
        if ({STALL, ACCESS_FAULT, DMEM_READ, DMEM_WRITE} !== 4'b0 || DMEM_BE !== 4'b0 ||
            DMEM_ADDR !== 32'd0 || DMEM_WDATA !== 32'd0 || DATA_MEM_READ_DATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_access: stall=%b fault=%b rd=%b wr=%b be=%b addr=%h rdata=%h, all must be 0",
                     STALL, ACCESS_FAULT, DMEM_READ, DMEM_WRITE, DMEM_BE, DMEM_ADDR, DATA_MEM_READ_DATA);
        end
    endtask

    task automatic test_random();
        logic [1:0] en;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            en = 2'($urandom_range(0, 3));
            if (n % 2 == 0) en = (n % 4 == 0) ? 2'b10 : 2'b01;
            a = $urandom;
            if (n % 3 != 0) a[0] = 1'b0;
            run_txn(en[1], en[0], 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                    $urandom_range(0, 3));
        end
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge CLK);
        MEM_READ_EN = 1'b1; MEM_FUNCT3 = 3'b010; MEM_ADDR = 32'h500;
        DMEM_READY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (STALL !== 1'b1 || DMEM_READ !== 1'b1 || ACCESS_FAULT !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait cyc%0d: stall=%b rd=%b fault=%b, want 1 1 0",
                         k, STALL, DMEM_READ, ACCESS_FAULT);
            end
        end
        @(negedge CLK);
        #1;
        m_rdata = 32'd0;
        checks++;
        if (STALL !== 1'b0 || DMEM_READ !== 1'b0 || ACCESS_FAULT !== 1'b1 ||
            DATA_MEM_READ_DATA !== 32'd0) begin
            errors++;
            $display("FAIL timeout_abort: stall=%b rd=%b fault=%b rdata=%h, want 0 0 1 0",
                     STALL, DMEM_READ, ACCESS_FAULT, DATA_MEM_READ_DATA);
        end
        @(negedge CLK);
        MEM_READ_EN = 1'b0;
        #1;
        checks++;
        if (ACCESS_FAULT !== 1'b0 || STALL !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: fault=%b stall=%b, want 0 0", ACCESS_FAULT, STALL);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_ready_outside_access();
        test_reset_mid_access();
        test_random();
`ifdef MEM_ACCESS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
